// File: rtl/q2_i2c_master.sv
// Command-driven I2C byte master: start/rstart, 8-bit write/read with ACK, stop; open-drain SCL/SDA.
// Phases are DIV clk each; Q1 phases wait for SCL high (clock stretching). wr is ignored while busy.
`timescale 1ns/1ps

module q2_i2c_master #(
  parameter int DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr,
  input  logic [11:0] wr_data,
  output logic [11:0] rd_data,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        scl_oe,
  output logic        sda_oe
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RSTART,
    S_START,
    S_BIT,
    S_ACK,
    S_STOP
  } state_t;

  localparam logic [7:0] TMR_LAST = 8'(DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  tmr_q, tmr_d;
  logic [1:0]  qtr_q, qtr_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  tx_q, tx_d;
  logic        ack_q, ack_d;
  logic        rd_q, rd_d;
  logic [7:0]  sr_q, sr_d;
  logic [7:0]  rx_q, rx_d;
  logic        nack_q, nack_d;
  logic        held_q, held_d;

  logic busy;
  logic stretch_ph;
  logic cnt_en;
  logic tick;
  logic wr_data_unused;

  assign wr_data_unused = wr_data[9];

  assign busy       = (state_q != S_IDLE);
  // Q1 of every phase group that releases SCL waits for the line to actually read high.
  assign stretch_ph = (qtr_q == 2'd1) &&
                      (state_q == S_RSTART || state_q == S_BIT ||
                       state_q == S_ACK    || state_q == S_STOP);
  assign cnt_en     = !(stretch_ph && !scl_in);
  assign tick       = busy && cnt_en && (tmr_q == TMR_LAST);

  assign rd_data = {busy, nack_q, 1'b0, held_q, rx_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      qtr_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      ack_q   <= 1'b0;
      rd_q    <= 1'b0;
      sr_q    <= '0;
      rx_q    <= '0;
      nack_q  <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      ack_q   <= ack_d;
      rd_q    <= rd_d;
      sr_q    <= sr_d;
      rx_q    <= rx_d;
      nack_q  <= nack_d;
      held_q  <= held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    ack_d   = ack_q;
    rd_d    = rd_q;
    sr_d    = sr_q;
    rx_d    = rx_q;
    nack_d  = nack_q;
    held_d  = held_q;

    if (state_q == S_IDLE) begin
      tmr_d = '0;
      qtr_d = '0;
      bit_d = '0;
      if (wr) begin
        case (wr_data[11:10])
          2'b01:        state_d = held_q ? S_RSTART : S_START;
          2'b00, 2'b10: state_d = held_q ? S_BIT : S_IDLE;
          default:      state_d = held_q ? S_STOP : S_IDLE;
        endcase
        if (state_d != S_IDLE) begin
          tx_d  = wr_data[7:0];
          ack_d = wr_data[8];
          rd_d  = (wr_data[11:10] == 2'b10);
        end
      end
    end else begin
      if (tick) begin
        tmr_d = '0;
      end else if (cnt_en) begin
        tmr_d = tmr_q + 8'd1;
      end

      if (tick) begin
        case (state_q)
          S_RSTART: begin
            qtr_d = 2'd1;
            if (qtr_q != 2'd0) begin
              state_d = S_START;
              qtr_d   = 2'd0;
            end
          end
          S_START: begin
            qtr_d = 2'd1;
            if (qtr_q != 2'd0) begin
              state_d = S_BIT;
              qtr_d   = 2'd0;
              bit_d   = 3'd0;
              held_d  = 1'b1;
            end
          end
          S_BIT: begin
            qtr_d = qtr_q + 2'd1;
            if (qtr_q == 2'd1) sr_d = {sr_q[6:0], sda_in};
            if (qtr_q == 2'd3) begin
              if (bit_q == 3'd7) state_d = S_ACK;
              else               bit_d   = bit_q + 3'd1;
            end
          end
          S_ACK: begin
            qtr_d = qtr_q + 2'd1;
            if (qtr_q == 2'd1 && !rd_q) nack_d = sda_in;
            if (qtr_q == 2'd3) begin
              state_d = S_IDLE;
              held_d  = 1'b1;
              if (rd_q) rx_d = sr_q;
            end
          end
          S_STOP: begin
            qtr_d = qtr_q + 2'd1;
            if (qtr_q == 2'd3) begin
              state_d = S_IDLE;
              held_d  = 1'b0;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  // SDA only moves while SCL is driven low, except the START and STOP edges.
  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (state_q)
      S_IDLE:   scl_oe = held_q;
      S_RSTART: scl_oe = (qtr_q == 2'd0);
      S_START: begin
        scl_oe = qtr_q[0];
        sda_oe = 1'b1;
      end
      S_BIT: begin
        scl_oe = (qtr_q == 2'd0) || (qtr_q == 2'd3);
        sda_oe = !rd_q && !tx_q[3'd7 - bit_q];
      end
      S_ACK: begin
        scl_oe = (qtr_q == 2'd0) || (qtr_q == 2'd3);
        sda_oe = rd_q && !ack_q;
      end
      S_STOP: begin
        scl_oe = (qtr_q == 2'd0);
        sda_oe = (qtr_q == 2'd0) || (qtr_q == 2'd1);
      end
      default: begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_q2_i2c_master.sv
// Bench for q2_i2c_master: scripted I2C slave on the open-drain lines, a bus decoder and a busy/status
// monitor compared against queues filled by a transaction-level model of the command set.
`timescale 1ns/1ps

module tb_q2_i2c_master;
  localparam int DIV = 4;
  localparam logic [31:0] EV_START = 32'h1000;
  localparam logic [31:0] EV_STOP  = 32'h2000;

  typedef struct {
    int          dur;
    logic [11:0] st;
  } st_exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr = 1'b0;
  logic [11:0] wr_data = '0;
  logic [11:0] rd_data;
  logic        scl_in, sda_in, scl_oe, sda_oe;
  logic        slave_scl_low = 1'b0;
  logic        slave_sda_low;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_ev[$];
  st_exp_t     exp_st[$];
  st_exp_t     cur;

  // slave script for the current command
  logic       plan_read = 1'b0;
  logic [7:0] plan_byte = '0;
  logic       plan_nack = 1'b0;
  int         stretch_req = 0;
  int         stretch_done = 0;
  int         s_idx = -1;

  // transaction-level model state
  logic       m_held = 1'b0;
  logic       m_nack = 1'b0;
  logic [7:0] m_rx = '0;

  always #5 clk = ~clk;

  assign scl_in = ~(scl_oe | slave_scl_low);
  assign sda_in = ~(sda_oe | slave_sda_low);
  assign slave_sda_low = (plan_read && s_idx >= 0 && s_idx < 8) ? ~plan_byte[3'(7 - s_idx)] :
                         (!plan_read && s_idx == 8) ? ~plan_nack : 1'b0;

  q2_i2c_master #(.DIV(DIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr      (wr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .scl_in  (scl_in),
    .sda_in  (sda_in),
    .scl_oe  (scl_oe),
    .sda_oe  (sda_oe)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] byte_ev(input logic [7:0] b, input logic a);
    return 32'h3000 | {23'b0, a, b};
  endfunction

  function automatic logic [11:0] model_status();
    return {1'b0, m_nack, 1'b0, m_held, m_rx};
  endfunction

  task automatic bus_event(input logic [31:0] ev);
    if (exp_ev.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL bus_event actual=0x%0h expected=none", ev);
    end else begin
      check("bus_event", ev, exp_ev.pop_front());
    end
  endtask

  // Bus decoder: START/STOP, 9-bit bytes, plus the slave's bit position (advances on SCL fall).
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  int         bcnt = 0;
  logic [8:0] bsh = '0;
  realtime    t_rise = 0.0;
  always @(scl_in or sda_in) begin
    if (scl_in && prev_scl && prev_sda && !sda_in && $realtime != t_rise) begin
      bus_event(EV_START);
      bcnt  = 0;
      s_idx = -1;
    end else if (scl_in && prev_scl && !prev_sda && sda_in && $realtime != t_rise) begin
      bus_event(EV_STOP);
      bcnt  = 0;
      s_idx = -1;
    end else if (scl_in && !prev_scl) begin
      t_rise = $realtime;
      bsh    = {bsh[7:0], sda_in};
      bcnt++;
      if (bcnt == 9) begin
        bus_event(byte_ev(bsh[8:1], bsh[0]));
        bcnt = 0;
      end
    end else if (!scl_in && prev_scl) begin
      s_idx = (s_idx == 8) ? 0 : s_idx + 1;
    end
    prev_scl = scl_in;
    prev_sda = sda_in;
  end

  // Slave clock stretch: hold SCL for 10 clk after the master releases it in bit 3.
  always begin
    @(posedge clk);
    #2;
    if (stretch_req != stretch_done && s_idx == 3 && scl_oe) begin
      stretch_done = stretch_req;
      slave_scl_low = 1'b1;
      for (int n = 0; n < 2000 && scl_oe; n++) begin
        @(posedge clk);
        #1;
      end
      repeat (10) @(posedge clk);
      #1;
      slave_scl_low = 1'b0;
    end
  end

  // Status monitor: measures each busy run and checks it and the status word when busy drops.
  int run = 0;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      run = 0;
    end else if (rd_data[11]) begin
      run++;
    end else if (run > 0) begin
      if (exp_st.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL busy_run unexpected actual=%0d expected=none", run);
      end else begin
        cur = exp_st.pop_front();
        check("busy_cycles", 32'(run), 32'(cur.dur));
        check("status", {20'b0, rd_data}, {20'b0, cur.st});
      end
      run = 0;
    end
  end

  task automatic issue(input logic [11:0] d);
    @(negedge clk);
    wr      = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr      = 1'b0;
  endtask

  task automatic do_cmd(input logic [11:0] d, input logic [7:0] sbyte, input logic snack,
                        input logic strch, input logic extra);
    logic [1:0] cmd;
    logic       acc;
    int         dur;
    int         n;
    cmd = d[11:10];
    acc = (cmd == 2'b01) || m_held;
    dur = 0;
    plan_read = acc && (cmd == 2'b10);
    plan_byte = sbyte;
    plan_nack = snack;
    if (acc) begin
      case (cmd)
        2'b01: begin
          dur = (m_held ? 4 : 2) * DIV + 36 * DIV;
          exp_ev.push_back(EV_START);
          exp_ev.push_back(byte_ev(d[7:0], snack));
          m_nack = snack;
          m_held = 1'b1;
        end
        2'b00: begin
          dur = 36 * DIV;
          exp_ev.push_back(byte_ev(d[7:0], snack));
          m_nack = snack;
        end
        2'b10: begin
          dur = 36 * DIV;
          exp_ev.push_back(byte_ev(sbyte, d[8]));
          m_rx = sbyte;
        end
        default: begin
          dur = 4 * DIV;
          exp_ev.push_back(EV_STOP);
          m_held = 1'b0;
        end
      endcase
      if (strch && cmd != 2'b11) begin
        dur += 10;
        stretch_req++;
      end
      exp_st.push_back('{dur: dur, st: model_status()});
    end
    issue(d);
    if (extra && acc) begin
      repeat ($urandom_range(1, 10)) @(negedge clk);
      wr      = 1'b1;
      wr_data = 12'($urandom);
      @(negedge clk);
      wr      = 1'b0;
    end
    n = 0;
    while (rd_data[11] && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout actual=busy expected=idle");
    end
    if (!acc) begin
      repeat (3) @(negedge clk);
      check("ignored_status", {20'b0, rd_data}, {20'b0, model_status()});
      check("ignored_lines", {30'b0, scl_oe, sda_oe}, 32'b0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_status", {20'b0, rd_data}, 32'h000);
    check("reset_lines", {30'b0, scl_oe, sda_oe}, 32'b0);
    rst_n = 1'b1;

    // Reset in the middle of bit 3 of 0xA5 (SCL and SDA both pulled at that point).
    exp_ev.push_back(EV_START);
    issue(12'h4A5);
    repeat (57) @(posedge clk);
    #2;
    check("pre_reset_lines", {30'b0, scl_oe, sda_oe}, 32'b11);
    rst_n = 1'b0;
    #1;
    check("async_release", {30'b0, scl_oe, sda_oe}, 32'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_status", {20'b0, rd_data}, 32'h000);

    do_cmd(12'h4A0, 8'h00, 1'b0, 1'b0, 1'b0);
    do_cmd(12'h800, 8'h5C, 1'b0, 1'b0, 1'b0);
    do_cmd(12'h900, 8'h3E, 1'b0, 1'b0, 1'b0);
    do_cmd(12'h455, 8'h00, 1'b1, 1'b0, 1'b0);
    do_cmd(12'hC00, 8'h00, 1'b0, 1'b0, 1'b0);
    do_cmd(12'h0FF, 8'h00, 1'b0, 1'b0, 1'b0);
    do_cmd(12'hC00, 8'h00, 1'b0, 1'b0, 1'b0);
    do_cmd(12'h8AA, 8'h00, 1'b0, 1'b0, 1'b0);
    do_cmd(12'h4C3, 8'h00, 1'b0, 1'b1, 1'b1);
    do_cmd(12'h800, 8'h96, 1'b0, 1'b1, 1'b0);
    do_cmd(12'h07E, 8'h00, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      int         r;
      logic [1:0] c;
      r = $urandom_range(0, 9);
      c = (r < 3) ? 2'b01 : (r < 6) ? 2'b00 : (r < 8) ? 2'b10 : 2'b11;
      do_cmd({c, 1'b0, 1'($urandom), 8'($urandom)}, 8'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
    end
    do_cmd(12'hC00, 8'h00, 1'b0, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    check("bus_events_left", 32'(exp_ev.size()), 32'd0);
    check("status_left", 32'(exp_st.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
